uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_transmitter between NUM_REQ requesters. Round-robin arbitration picks one byte
//   at a time, latches it, pulses the transmitter start and waits for its completion flag. It then
//   inserts an idle gap before the next grant. Sits between on-chip byte sources (ALU result,
//   status, debug) and the single tx line.
// PARAMETERS
//   NUM_REQ        4     number of requesters (>=2)
//   DATA_W         8     byte width, matches transmitter data_in
//   GAP_CYCLES     2     idle clocks after each completed byte (0 allowed)
//   TIMEOUT_CYCLES 8192  WAIT_DONE watchdog limit (used only with UART_TX_ARB_TIMEOUT_EN)
// PORTS
//   clk          in   1                 system clock, all logic on posedge
//   reset        in   1                 asynchronous, active-high reset
//   req_valid    in   NUM_REQ           requester i has a byte; held until its req_ready pulse
//   req_data     in   NUM_REQ*DATA_W    requester i byte at [i*DATA_W +: DATA_W]
//   req_ready    out  NUM_REQ           one-hot, one-cycle accept pulse
//   grant_id     out  $clog2(NUM_REQ)   index of the requester currently being served
//   tx_start     out  1                 one-cycle start pulse to transmitter start_transmit
//   tx_data      out  DATA_W            latched byte to transmitter data_in, stable while busy
//   tx_done      in   1                 transmitter transmission_done (sticky high, cleared by start)
//   busy         out  1                 high whenever state != IDLE
//   timeout_err  out  1                 watchdog flag (tied 0 without the macro)
// BEHAVIOUR
//   Reset (async): state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, busy=0,
//     timeout_err=0, rr pointer=NUM_REQ-1 so requester 0 wins first. An in-flight byte is dropped.
//   All outputs are registered. FSM states: IDLE -> START -> WAIT_CLR -> WAIT_DONE -> GAP -> IDLE.
//   IDLE: on an edge where |req_valid, pick g = first valid index scanning ptr+1, ptr+2, ...
//     (mod NUM_REQ). Latch tx_data <= req_data[g], grant_id <= g, ptr <= g. Go to START.
//   START (1 cycle): tx_start=1 and req_ready[g]=1 in the same cycle. Requester may change
//     req_data/req_valid after this cycle. Go to WAIT_CLR.
//   WAIT_CLR (1 cycle): ignore tx_done, because the transmitter's sticky done is still high from
//     the previous byte. Go to WAIT_DONE.
//   WAIT_DONE: stay until tx_done==1, then go to GAP; with GAP_CYCLES==0 go straight to IDLE.
//   GAP: count GAP_CYCLES clocks, then go to IDLE.
//   Throughput: request-to-tx_start latency is 1 clock. A back-to-back grant can come no earlier
//     than GAP_CYCLES+1 clocks after tx_done is seen.
//   req_valid is sampled only in IDLE. Valid changes while busy are ignored. A requester dropping
//     valid after the IDLE sample edge still has its byte sent.
//   Requesters not granted keep waiting; round-robin bounds the wait to NUM_REQ-1 bytes.
//   Only one of req_ready is ever high, and only during the START cycle.
//   tx_start is never high in two consecutive cycles.
//   tx_done rising in WAIT_CLR is ignored. tx_done already high on WAIT_DONE entry ends the wait
//     at once; this relies on the 1-cycle clear of the transmitter.
// CONFIGURATION
//   UART_TX_ARB_TIMEOUT_EN defined: a counter runs in WAIT_DONE. If it reaches TIMEOUT_CYCLES
//     without tx_done, the FSM goes to GAP and timeout_err is set to 1. timeout_err is sticky
//     until reset or the next byte completing normally (tx_done seen in WAIT_DONE). The counter
//     clears on WAIT_DONE entry.
//   UART_TX_ARB_TIMEOUT_EN undefined: no counter; WAIT_DONE waits indefinitely;
//     timeout_err is constant 0.
// TESTING (bench uses a transmitter model: done clears 1 clk after start, sets 40 clks later)
//   1 Reset asserted mid-WAIT_DONE -> busy, tx_start, req_ready go 0 without a clock edge;
//     first grant after release goes to requester 0.
//   2 req_valid=4'b0010, data1=8'h5A -> next clk: tx_start=1, req_ready=4'b0010, tx_data=8'h5A,
//     grant_id=1; busy stays high until 2 clks after done.
//   3 req_valid=4'b1111 held, ready re-asserted -> grant sequence 0,1,2,3,0,1; no requester served
//     twice in a row.
//   4 tx_done held high (sticky) at request time -> no early finish; busy holds for the full 40
//     clks of the model.
//   5 GAP_CYCLES=0, two requesters valid -> second tx_start exactly 1 clk after done is seen in
//     WAIT_DONE.
//   6 With macro, TIMEOUT_CYCLES=100, model never sets done -> timeout_err=1 after 100 WAIT_DONE
//     clks, FSM returns to IDLE, next request served. The following normal byte clears timeout_err.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte sources. A round-robin
//   arbiter grants one byte at a time, latches it, pulses the transmitter
//   start and waits for its completion flag. After each byte it holds an idle
//   gap of GAP_CYCLES clocks before the next grant.
//
//   Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable a WAIT_DONE
//   watchdog (TIMEOUT_CYCLES clocks) that aborts the byte and sets the sticky
//   timeout_err flag. Without the macro timeout_err is constant 0.
//
// Ports
//   clk          system clock, posedge
//   reset        asynchronous, active-high reset
//   req_valid    per-requester byte available, held until its req_ready pulse
//   req_data     requester i byte at [i*DATA_W +: DATA_W]
//   req_ready    one-hot, one-cycle accept pulse (START cycle only)
//   grant_id     index of the requester currently being served
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      latched byte to the transmitter, stable while busy
//   tx_done      transmitter completion flag (sticky, cleared by start)
//   busy         high whenever the arbiter is not idle
//   timeout_err  sticky watchdog flag
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_done,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int unsigned ID_W     = $clog2(NUM_REQ);
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (NUM_REQ < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_CLR,
        WAIT_DONE,
        GAP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     rr_ptr;
    logic [GAP_W-1:0]    gap_cnt;
    logic [ID_W-1:0]     scan_idx;
    logic [ID_W-1:0]     pick_id;
    logic                pick_found;
    logic [DATA_W-1:0]   pick_data;
    logic                wd_expired;

    logic [NUM_REQ-1:0]  req_ready_d;
    logic                tx_start_d;
    logic                busy_d;
    logic                timeout_err_d;

    // Round-robin pick: first valid index after the last grant, wrapping.
    always_comb begin
        scan_idx   = '0;
        pick_id    = '0;
        pick_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_id    = scan_idx;
                pick_found = 1'b1;
            end
        end
        pick_data = req_data[pick_id*DATA_W +: DATA_W];
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Counter only runs in WAIT_DONE; any other state clears it, so it
    // starts from zero on every WAIT_DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expired = (state == WAIT_DONE) && !tx_done &&
                        (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (|req_valid) state_next = START;
            START:     state_next = WAIT_CLR;
            // tx_done is still the previous byte's sticky flag here.
            WAIT_CLR:  state_next = WAIT_DONE;
            WAIT_DONE: if (tx_done || wd_expired)
                           state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:       if (gap_cnt == GAP_W'(GAP_LAST)) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from
    // state_next so the registers line up with the state they describe.
    always_comb begin
        tx_start_d  = (state_next == START);
        busy_d      = (state_next != IDLE);
        req_ready_d = '0;
        if (state_next == START) begin
            req_ready_d[pick_id] = 1'b1;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        timeout_err_d = timeout_err;
        if (state == WAIT_DONE && tx_done) begin
            timeout_err_d = 1'b0;
        end else if (wd_expired) begin
            timeout_err_d = 1'b1;
        end
`else
        timeout_err_d = 1'b0;
`endif
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready   <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            gap_cnt     <= '0;
        end else begin
            req_ready   <= req_ready_d;
            tx_start    <= tx_start_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
            if (state == IDLE && pick_found) begin
                tx_data  <= pick_data;
                grant_id <= pick_id;
                rr_ptr   <= pick_id;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table-driven byte grants plus hand-written
// sequences for reset, zero-gap back-to-back grants and the watchdog.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    // Instance A: GAP_CYCLES=2, short watchdog
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b1;
    logic        busy;
    logic        timeout_err;

    // Instance B: GAP_CYCLES=0
    logic [3:0]  req_valid_b = '0;
    logic [31:0] req_data_b = '0;
    logic [3:0]  req_ready_b;
    logic [1:0]  grant_id_b;
    logic        tx_start_b;
    logic [7:0]  tx_data_b;
    logic        tx_done_b = 1'b1;
    logic        busy_b;
    logic        timeout_err_b;

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)
    ) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .grant_id(grant_id_b), .tx_start(tx_start_b),
        .tx_data(tx_data_b), .tx_done(tx_done_b), .busy(busy_b), .timeout_err(timeout_err_b)
    );

    // Transmitter models: done clears on the edge that samples start and
    // sets 40 clocks later (unless never_done suppresses it).
    logic never_done = 1'b0;
    int   cnt_a = 0;
    int   cnt_b = 0;

    always @(posedge clk) begin
        if (tx_start) begin
            tx_done <= 1'b0;
            cnt_a   <= 40;
        end else if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1 && !never_done) tx_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (tx_start_b) begin
            tx_done_b <= 1'b0;
            cnt_b     <= 40;
        end else if (cnt_b != 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) tx_done_b <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_data;
        logic        exp_err;
    } row_t;

    // One full byte on instance A: request, START checks, then completion
    // timing (busy falls 44 clocks after the START edge, 3 edges after done
    // is first visible).
    task automatic apply_row(input row_t r, input string tag);
        int n;
        int done_at;
        req_valid = r.valid;
        req_data  = r.data;
        step();
        check({tag, ".tx_start"}, 32'(tx_start), 32'd1);
        check({tag, ".req_ready"}, 32'(req_ready), 32'(r.exp_ready));
        check({tag, ".grant_id"}, 32'(grant_id), 32'(r.exp_gid));
        check({tag, ".tx_data"}, 32'(tx_data), 32'(r.exp_data));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'(r.exp_err));
        req_valid = req_valid & ~r.exp_ready;
        step();
        check({tag, ".start_drop"}, 32'(tx_start), 32'd0);
        check({tag, ".ready_drop"}, 32'(req_ready), 32'd0);
        n = 1;
        done_at = 0;
        while (busy && n < 200) begin
            step();
            n++;
            if (tx_done && done_at == 0) done_at = n;
        end
        check({tag, ".busy_len"}, 32'(n), 32'd44);
        check({tag, ".done_to_idle"}, 32'(n - done_at), 32'd3);
    endtask

    row_t rows[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;

        rows[0] = '{4'b1111, 32'hA3A2A1A0, 4'b0001, 2'd0, 8'hA0, 1'b0};
        rows[1] = '{4'b1111, 32'hB3B2B1B0, 4'b0010, 2'd1, 8'hB1, 1'b0};
        rows[2] = '{4'b1111, 32'hC3C2C1C0, 4'b0100, 2'd2, 8'hC2, 1'b0};
        rows[3] = '{4'b1111, 32'hD3D2D1D0, 4'b1000, 2'd3, 8'hD3, 1'b0};
        rows[4] = '{4'b1111, 32'hE3E2E1E0, 4'b0001, 2'd0, 8'hE0, 1'b0};
        rows[5] = '{4'b1111, 32'hF3F2F1F0, 4'b0010, 2'd1, 8'hF1, 1'b0};
        rows[6] = '{4'b0010, 32'h11225A33, 4'b0010, 2'd1, 8'h5A, 1'b0};
        rows[7] = '{4'b1001, 32'h7E000081, 4'b1000, 2'd3, 8'h7E, 1'b0};
        rows[8] = '{4'b1001, 32'h7E000081, 4'b0001, 2'd0, 8'h81, 1'b0};
        rows[9] = '{4'b0100, 32'h00C50000, 4'b0100, 2'd2, 8'hC5, 1'b0};

        // Reset state, checked before any clock edge
        #1 reset = 1'b1;
        #3;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.tx_start", 32'(tx_start), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.tx_data", 32'(tx_data), 32'd0);
        check("rst.grant_id", 32'(grant_id), 32'd0);
        check("rst.timeout_err", 32'(timeout_err), 32'd0);
        check("rst.busy_b", 32'(busy_b), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        check("idle.busy", 32'(busy), 32'd0);
        check("idle.tx_start", 32'(tx_start), 32'd0);

        for (int i = 0; i < 10; i++) begin
            apply_row(rows[i], $sformatf("row%0d", i));
        end

        // Reset in the middle of WAIT_DONE drops the byte and rewinds the pointer
        req_valid = 4'b0100;
        req_data  = 32'h00990000;
        step();
        check("mid.tx_start", 32'(tx_start), 32'd1);
        check("mid.grant_id", 32'(grant_id), 32'd2);
        req_valid = '0;
        repeat (10) step();
        check("mid.busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async.busy", 32'(busy), 32'd0);
        check("async.tx_start", 32'(tx_start), 32'd0);
        check("async.req_ready", 32'(req_ready), 32'd0);
        check("async.tx_data", 32'(tx_data), 32'd0);
        check("async.grant_id", 32'(grant_id), 32'd0);
        step();
        step();
        reset = 1'b0;
        apply_row('{4'b1111, 32'h44332211, 4'b0001, 2'd0, 8'h11, 1'b0}, "post_rst");

        // Zero-gap instance: second start exactly one clock after done is seen
        req_valid_b = 4'b0011;
        req_data_b  = 32'h0000BBAA;
        step();
        check("gap0.start1", 32'(tx_start_b), 32'd1);
        check("gap0.ready1", 32'(req_ready_b), 32'd1);
        check("gap0.data1", 32'(tx_data_b), 32'hAA);
        req_valid_b = 4'b0010;
        step();
        n = 0;
        while (!tx_done_b && n < 100) begin
            step();
            n++;
        end
        check("gap0.done_wait", 32'(n), 32'd40);
        step();
        check("gap0.start_gap", 32'(tx_start_b), 32'd0);
        check("gap0.busy_gap", 32'(busy_b), 32'd0);
        step();
        check("gap0.start2", 32'(tx_start_b), 32'd1);
        check("gap0.gid2", 32'(grant_id_b), 32'd1);
        check("gap0.ready2", 32'(req_ready_b), 32'b0010);
        check("gap0.data2", 32'(tx_data_b), 32'hBB);
        req_valid_b = '0;
        n = 0;
        while (busy_b && n < 100) begin
            step();
            n++;
        end
        check("gap0.idle", 32'(busy_b), 32'd0);
        check("gap0.timeout_err", 32'(timeout_err_b), 32'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog: transmitter never completes
        never_done = 1'b1;
        req_valid = 4'b0100;
        req_data  = 32'h00770000;
        step();
        check("to.tx_start", 32'(tx_start), 32'd1);
        check("to.grant_id", 32'(grant_id), 32'd2);
        req_valid = '0;
        repeat (101) step();
        check("to.err_before", 32'(timeout_err), 32'd0);
        check("to.busy_before", 32'(busy), 32'd1);
        step();
        check("to.err_set", 32'(timeout_err), 32'd1);
        check("to.busy_gap", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("to.gap_len", 32'(n), 32'd2);
        check("to.err_sticky", 32'(timeout_err), 32'd1);
        never_done = 1'b0;
        apply_row('{4'b0001, 32'h000000C3, 4'b0001, 2'd0, 8'hC3, 1'b1}, "after_to");
        check("to.err_clear", 32'(timeout_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
